// File: rtl/aes_result_tx_pkg.sv
// Shared definitions for the AES result read-back path.
package aes_pkg;
    localparam int BLOCK_BITS = 128;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        SHIFT
    } tx_state_t;
endpackage

// File: rtl/aes_result_tx_rise_detect.sv
// Single-bit rising-edge detector; the strobe is combinational from the registered previous level.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/aes_result_tx.sv
// Captures a 128-bit AES result on a done-strobe rising edge and shifts it out MSB-first while cs is low.
module aes_result_tx
    import aes_pkg::*;
#(
    parameter int datasize = BLOCK_BITS,
    parameter int CNTW     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [datasize-1:0] data_in,
    input  logic                cs,
    output logic                miso,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                aborted
);
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(datasize - 1);

    tx_state_t           state;
    logic [datasize-1:0] hold;
    logic [datasize-1:0] shreg;
    logic [CNTW-1:0]     cnt;
    logic                capture;
    logic [datasize-1:0] shifted;

    rise_detect u_load_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (load),
        .rise (capture)
    );

    assign shifted = {shreg[datasize-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hold    <= '0;
            shreg   <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        hold  <= data_in;
                        shreg <= data_in;
                        cnt   <= '0;
                        state <= READY;
                    end
                end
                READY: begin
                    // A newer result replaces the pending one until the host starts clocking.
                    if (capture) begin
                        hold  <= data_in;
                        shreg <= data_in;
                    end else if (!cs) begin
                        shreg <= shifted;
                        cnt   <= CNTW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Capture edges are deliberately ignored here so the frame stays intact.
                    if (cs) begin
                        shreg   <= hold;
                        cnt     <= '0;
                        aborted <= 1'b1;
                        state   <= READY;
                    end else if (cnt == LAST_BIT) begin
                        shreg <= shifted;
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        shreg <= shifted;
                        cnt   <= cnt + CNTW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == READY) || (state == SHIFT);
    assign busy  = (state == SHIFT);
    assign miso  = ready ? shreg[datasize-1] : 1'b0;
endmodule

// File: tb/tb_aes_result_tx.sv
// Randomized and directed bench for aes_result_tx against a bit-index model of the read-back port.
module tb_aes_result_tx;
    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [127:0] data_in;
    logic         cs;
    logic         miso, ready, busy, done, aborted;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    int abort_seen = 0;
    bit checking = 0;

    // Model: whether a block is held, which bit index is next, and whether a frame is open.
    bit           m_have = 0;
    bit           m_in_frame = 0;
    int           m_sent = 0;
    bit           m_prev_load = 0;
    logic [127:0] m_blk = '0;
    bit           m_done = 0;
    bit           m_abort = 0;

    aes_result_tx #(.datasize(128), .CNTW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .cs      (cs),
        .miso    (miso),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .aborted (aborted)
    );

    always #5 clk = ~clk;

    task automatic check1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic checkn(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit rise;
        m_done  = 0;
        m_abort = 0;
        if (rst) begin
            m_have = 0; m_in_frame = 0; m_sent = 0; m_prev_load = 0; m_blk = '0;
        end else begin
            rise = load && !m_prev_load;
            if (m_in_frame) begin
                if (cs) begin
                    m_in_frame = 0; m_sent = 0; m_abort = 1;
                end else begin
                    m_sent++;
                    if (m_sent == 128) begin
                        m_have = 0; m_in_frame = 0; m_sent = 0; m_done = 1;
                    end
                end
            end else if (rise) begin
                m_blk = data_in; m_have = 1; m_sent = 0;
            end else if (m_have && !cs) begin
                m_in_frame = 1; m_sent = 1;
            end
            m_prev_load = load;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            tests++;
            if (miso !== (m_have ? m_blk[127 - m_sent] : 1'b0) || ready !== m_have ||
                busy !== m_in_frame || done !== m_done || aborted !== m_abort) begin
                fails++;
                $display("FAIL cycle_model @%0t: got miso=%b ready=%b busy=%b done=%b aborted=%b expected %b %b %b %b %b",
                         $time, miso, ready, busy, done, aborted,
                         m_have ? m_blk[127 - m_sent] : 1'b0, m_have, m_in_frame, m_done, m_abort);
            end
            if (done === 1'b1) done_seen++;
            if (aborted === 1'b1) abort_seen++;
        end
    end

    task automatic frame(input int n, input int load_at, input logic [127:0] ld,
                         output logic [127:0] rec);
        rec = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rec = {rec[126:0], miso};
            cs = 1'b0;
            if (i == load_at) begin
                load = 1'b1;
                data_in = ld;
            end
        end
        @(negedge clk);
        cs = 1'b1;
    endtask

    task automatic capture(input logic [127:0] d);
        @(negedge clk);
        load = 1'b1;
        data_in = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    localparam logic [127:0] BLK1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BEEF = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [127:0] BLK3 = 128'h80000000_00000000_00000000_00000001;
    localparam logic [127:0] BLKA = {16{8'hAA}};
    localparam logic [127:0] BLKB = {16{8'h55}};

    initial begin
        logic [127:0] rec;
        int d0, a0;
        rst = 1'b1; load = 1'b0; cs = 1'b1; data_in = '0;
        repeat (2) @(negedge clk);
        check1("reset_ready", ready, 1'b0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_miso", miso, 1'b0);
        check1("reset_done", done, 1'b0);
        rst = 1'b0;
        checking = 1;

        // Full frame
        @(negedge clk);
        load = 1'b1; data_in = BLK1;
        @(negedge clk);
        check1("t1_ready_after_capture", ready, 1'b1);
        check1("t1_miso_bit127", miso, 1'b0);
        load = 1'b0;
        d0 = done_seen;
        frame(128, -1, '0, rec);
        check128("t1_stream", rec, BLK1);
        check1("t1_done_pulse", done, 1'b1);
        check1("t1_ready_after_done", ready, 1'b0);
        @(negedge clk);
        checkn("t1_done_count", done_seen - d0, 1);

        // Level load: only the first value is captured
        @(negedge clk);
        load = 1'b1; data_in = BLK1;
        repeat (5) @(negedge clk);
        data_in = BEEF;
        repeat (295) @(negedge clk);
        frame(128, -1, '0, rec);
        check128("t2_stream", rec, BLK1);
        load = 1'b0;

        // Abort and retry
        capture(BLK3);
        a0 = abort_seen;
        frame(40, -1, '0, rec);
        check128("t3_partial", rec, {88'h0, BLK3[127:88]});
        frame(128, -1, '0, rec);
        check128("t3_retry_stream", rec, BLK3);
        checkn("t3_abort_count", abort_seen - a0, 1);

        // Overwrite in READY
        capture(BLKA);
        capture(BLKB);
        frame(128, -1, '0, rec);
        check128("t4_stream", rec, BLKB);

        // Capture edge during a frame is ignored
        capture(BLKA);
        frame(128, 60, BLKB, rec);
        check128("t5_stream", rec, BLKA);
        repeat (3) @(negedge clk);
        check1("t5_not_captured", ready, 1'b0);
        load = 1'b0;

        // Reset mid-frame
        capture(BLK1);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            cs = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check1("t6_miso", miso, 1'b0);
        check1("t6_ready", ready, 1'b0);
        check1("t6_busy", busy, 1'b0);
        rst = 1'b0;
        d0 = done_seen;
        repeat (130) @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        checkn("t6_no_done", done_seen - d0, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) load = ~load;
            data_in = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 40) == 0) cs = ~cs;
            else if (cs && $urandom_range(0, 6) == 0) cs = 1'b0;
            rst = ($urandom_range(0, 900) == 0);
        end
        @(negedge clk);
        rst = 1'b0; cs = 1'b1; load = 1'b0;
        repeat (2) @(negedge clk);
        checking = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes_result_tx.md
# aes_result_tx

Serial read-back port for the AES core's 128-bit results. It captures a result block on the rising edge of a done strobe, either `doneenc` with `encrypted` or `donedec` with `decrypted`. It then shifts the block out MSB-first on `miso`, one bit per `clk` while the host holds `cs` low, using the same framing as the input SPI slaves. It sits downstream of the cipher and inverse-cipher outputs. One instance per result bus is instantiated at top level.

## Interface
Parameters:
- `datasize`, default 128: block width in bits.
- `CNTW`, default 8: bit-counter width; must satisfy 2^CNTW > `datasize`.

Ports:
- `clk` input 1: sole clock.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `load` input 1: result-done level (`doneenc`/`donedec`). Only its rising edge captures.
- `data_in` input `datasize`: result block, sampled on the capture cycle.
- `cs` input 1: host chip select, active-low.
- `miso` output 1: serial data out.
- `ready` output 1: a block is held and untransmitted (READY or SHIFT).
- `busy` output 1: frame in progress (SHIFT).
- `done` output 1: one-cycle pulse after the last bit.
- `aborted` output 1: one-cycle pulse when `cs` deasserts mid-frame.

## Operation
- Edge detect: `load_q` registers `load`. The capture condition is `load & ~load_q`. A level held high captures exactly once.
- Registers: `hold` (`datasize`, the captured copy), `shreg` (`datasize`, the shift image), `cnt` (`CNTW`), and the state.
- States:
  - IDLE: on capture, `hold` ← `data_in`, `shreg` ← `data_in` → READY.
  - READY: on capture, overwrite `hold` and `shreg` (newest result wins), stay READY. Otherwise, if `cs`=0: shift `shreg` left by 1, `cnt` ← 1 → SHIFT.
  - SHIFT, `cs`=0, `cnt` < `datasize`−1: shift left, `cnt`+1.
  - SHIFT, `cs`=0, `cnt` = `datasize`−1: final shift, `done` ← 1 next cycle → IDLE.
  - SHIFT, `cs`=1: abort. `shreg` ← `hold`, `cnt` ← 0, `aborted` pulse → READY. The whole block is retransmitted in the next frame.
  - Capture edges in SHIFT are ignored; the in-flight frame is not corrupted.
- Output decode:
  - `miso` = `shreg[datasize-1]` in READY/SHIFT, else 0.
  - `ready` = (state==READY) | (state==SHIFT).
  - `busy` = (state==SHIFT).
- Shift-in LSB is 0.
- Host clocking beyond `datasize` bits in IDLE sees `miso`=0 with no state change.

## Timing
- Reset values:
  - State = IDLE; `hold`, `shreg`, `cnt`, `load_q` = 0.
  - `miso`, `ready`, `busy`, `done`, `aborted` = 0.
- A synchronous `rst` mid-frame returns everything to reset values on that edge. The held block is discarded.
- Capture latency: `load` rises at edge N, is sampled at N. `ready`=1 and `miso`=bit 127 from N+1.
- Bit k (k=0 is the MSB) is on `miso` during the k-th cycle in which `cs` is sampled low. The host samples it at that edge, then it shifts.
- A full frame is exactly `datasize` consecutive `cs`-low cycles.
- `done` is high the cycle after the last sampled bit. `ready`/`busy` are 0 in that same cycle.
- Capture edge in the same cycle as the final shift: ignored (state was SHIFT). The host must re-pulse `load`.
- `load` and `rst` in the same cycle: `rst` wins, and `load_q` resets to 0.
- `cs` high for a single cycle mid-frame counts as an abort; no glitch tolerance.

## Structure
- Shared package `aes_pkg`:
  - `BLOCK_BITS` = 128.
  - Enum `tx_state_t` {IDLE, READY, SHIFT}.
- Sub-module `rise_detect` (1-bit, synchronous reset) produces the capture strobe. It is reusable for `cdone`/`expdone` gating.
- Everything else is inline: one state register, `cnt`, and the `hold`/`shreg` datapath.

## Test plan
1. Full frame:
   - Stimulus: `load` 0→1 with `data_in`=0x00112233445566778899AABBCCDDEEFF, then `cs` low for 128 cycles.
   - Required: `miso` stream equals the block MSB-first; `done`=1 exactly one cycle after bit 127; `ready`=0 afterwards.
2. Level load:
   - Stimulus: `load` held high for 300 cycles with `data_in` changing to 0xDEADBEEF… at cycle 5.
   - Required: the first value is captured only; the frame returns the original block.
3. Abort and retry:
   - Stimulus: data 0x8000…0001; `cs` low for 40 cycles, high for 1 cycle, low for 128 cycles.
   - Required: `aborted` pulses once; the second frame returns the full block starting at bit 127 (`miso`=1 first).
4. Overwrite:
   - Stimulus: capture A=0xAA…AA, drop `load`, capture B=0x55…55 in READY, run a frame.
   - Required: `miso` shows B.
5. Busy ignore:
   - Stimulus: start a frame of A, raise `load` with B at bit 60.
   - Required: A is completed intact; state is IDLE after `done`; B is not captured.
6. Reset mid-frame:
   - Stimulus: `rst` at bit 70.
   - Required: the next cycle has `miso`=0, `ready`=0, `busy`=0; a further `cs`-low sequence produces no `done`.
